// File: rtl/sd_otf_converter_pkg.sv
// Shared online-arithmetic definitions: radix-4 signed-digit format used by the
// signed-digit adder stage and the on-the-fly converter.
package sd_otf_converter_pkg;

  localparam int unsigned RADIX      = 4;
  localparam int unsigned RADIX_LOG2 = 2;
  localparam int unsigned DIGIT_W    = 3;

  typedef logic signed [DIGIT_W-1:0] sd_digit_t;

  localparam sd_digit_t DIGIT_MIN     = -3;
  localparam sd_digit_t DIGIT_MAX     = 3;
  localparam sd_digit_t DIGIT_ILLEGAL = 3'b100;

endpackage

// File: rtl/sd_otf_converter_if.sv
// Digit-in / result-out handshake bundle of the on-the-fly converter.
interface sd_otf_converter_if #(
  parameter int unsigned NO_OF_DIGITS = 8,
  parameter int unsigned RADIX_BITS   = 3
);

  logic [RADIX_BITS-1:0]   din;
  logic                    din_valid;
  logic                    din_ready;
  logic [2*NO_OF_DIGITS:0] dout;
  logic                    dout_err;
  logic                    dout_valid;
  logic                    dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_err, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_err, dout_valid
  );

endinterface

// File: rtl/sd_otf_converter_otf_digit_select.sv
// Maps one radix-4 signed digit to the Q/QM append bits and source selects.
module otf_digit_select
  import sd_otf_converter_pkg::*;
(
  input  sd_digit_t             d_i,
  output logic [RADIX_LOG2-1:0] q_app_o,
  output logic [RADIX_LOG2-1:0] qm_app_o,
  output logic                  sel_q_for_q_o,
  output logic                  sel_q_for_qm_o,
  output logic                  illegal_o
);

  // (4+d) mod 4 == d mod 4 and (3+d) mod 4 == (d-1) mod 4, so the append bits
  // do not depend on which register is shifted.
  always_comb begin
    q_app_o        = d_i[RADIX_LOG2-1:0];
    qm_app_o       = d_i[RADIX_LOG2-1:0] - RADIX_LOG2'(1);
    sel_q_for_q_o  = !d_i[DIGIT_W-1];
    sel_q_for_qm_o = !d_i[DIGIT_W-1] && (d_i != '0);
    illegal_o      = (d_i == DIGIT_ILLEGAL);
  end

endmodule

// File: rtl/sd_otf_converter.sv
// Digit-serial radix-4 on-the-fly converter: MSD-first signed digits in,
// two's-complement frame value out over a valid/ready handshake.
module sd_otf_converter
  import sd_otf_converter_pkg::*;
#(
  parameter int unsigned NO_OF_DIGITS = 8,
  parameter int unsigned RADIX_BITS   = 3,
  parameter int unsigned RADIX        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sd_otf_converter_if.slave    bus
);

  localparam int unsigned W     = 2 * NO_OF_DIGITS + 1;
  localparam int unsigned SH    = $clog2(RADIX);
  localparam int unsigned CNT_W = (NO_OF_DIGITS > 1) ? $clog2(NO_OF_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NO_OF_DIGITS - 1);

  logic [W-1:0]     q_q, q_d, qm_q, qm_d, dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, dout_err_q, dout_err_d, dout_valid_q, dout_valid_d;

  logic [RADIX_BITS-1:0] din_w;
  sd_digit_t             digit;
  logic [SH-1:0]         q_app, qm_app;
  logic                  sel_q_for_q, sel_q_for_qm, illegal;
  logic [W-1:0]          q_next, qm_next;
  logic                  accept, last;

  assign din_w = bus.din;
  assign digit = din_w;

  otf_digit_select u_sel (
    .d_i            (digit),
    .q_app_o        (q_app),
    .qm_app_o       (qm_app),
    .sel_q_for_q_o  (sel_q_for_q),
    .sel_q_for_qm_o (sel_q_for_qm),
    .illegal_o      (illegal)
  );

  assign bus.din_ready  = !(dout_valid_q && !bus.dout_ready);
  assign bus.dout       = dout_q;
  assign bus.dout_err   = dout_err_q;
  assign bus.dout_valid = dout_valid_q;

  assign accept  = bus.din_valid && bus.din_ready;
  assign last    = (cnt_q == LAST);
  assign q_next  = sel_q_for_q  ? {q_q[W-1-SH:0], q_app}  : {qm_q[W-1-SH:0], q_app};
  assign qm_next = sel_q_for_qm ? {q_q[W-1-SH:0], qm_app} : {qm_q[W-1-SH:0], qm_app};

  always_comb begin
    q_d          = q_q;
    qm_d         = qm_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    dout_d       = dout_q;
    dout_err_d   = dout_err_q;
    dout_valid_d = dout_valid_q;
    if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end
    // A completing accept overrides the consume clear so back-to-back frames
    // keep dout_valid asserted with the fresh value.
    if (accept) begin
      if (last) begin
        q_d          = '0;
        qm_d         = '1;
        cnt_d        = '0;
        err_d        = 1'b0;
        dout_d       = q_next;
        dout_err_d   = err_q | illegal;
        dout_valid_d = 1'b1;
      end else begin
        q_d   = q_next;
        qm_d  = qm_next;
        cnt_d = cnt_q + CNT_W'(1);
        err_d = err_q | illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q          <= '0;
      qm_q         <= '1;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      dout_q       <= '0;
      dout_err_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      qm_q         <= qm_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
      dout_err_q   <= dout_err_d;
      dout_valid_q <= dout_valid_d;
    end
  end

endmodule

// File: tb/tb_sd_otf_converter.sv
// Directed self-checking bench for sd_otf_converter with N=8 (17-bit result).
module tb_sd_otf_converter;

  localparam int unsigned N = 8;
  localparam int unsigned W = 2 * N + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sd_otf_converter_if #(.NO_OF_DIGITS(N), .RADIX_BITS(3)) bus ();

  sd_otf_converter #(.NO_OF_DIGITS(N), .RADIX_BITS(3), .RADIX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef logic [2:0] frame_t [N];

  task automatic send_digit(input logic [2:0] d, input int gap);
    int g;
    for (int i = 0; i < gap; i++) @(negedge clk);
    bus.din       = d;
    bus.din_valid = 1'b1;
    g = 0;
    while (!bus.din_ready && g < 64) begin
      @(negedge clk);
      g++;
    end
    if (g >= 64) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: din_ready stayed %b, required 1", bus.din_ready);
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int maxgap);
    for (int k = 0; k < int'(N); k++)
      send_digit(f[k], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] exp, input logic exp_err);
    checks++;
    if (bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b, required 1", name, bus.dout_valid);
    end
    checks++;
    if (bus.dout !== exp) begin
      errors++;
      $display("FAIL %s dout: got %h, required %h", name, bus.dout, exp);
    end
    checks++;
    if (bus.dout_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b, required %b", name, bus.dout_err, exp_err);
    end
    @(negedge clk);
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_pulse: got %b, required 0", name, bus.dout_valid);
    end
  endtask

  function automatic frame_t fill(input logic [2:0] d);
    frame_t f;
    for (int k = 0; k < int'(N); k++) f[k] = d;
    return f;
  endfunction

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.dout !== '0 || bus.dout_err !== 1'b0 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%h err=%b valid=%b, required 0/0/0",
               bus.dout, bus.dout_err, bus.dout_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_din_ready: got %b, required 1", bus.din_ready);
    end
  endtask

  task automatic test_extremes();
    send_frame(fill(3'd3), 0);
    check_result("pos_max", 17'h0FFFF, 1'b0);
    send_frame(fill(3'b101), 0);
    check_result("neg_max", 17'h10001, 1'b0);
  endtask

  task automatic test_mixed();
    frame_t f;
    f = fill(3'd0);
    f[0] = 3'd1;
    f[1] = 3'b111;
    send_frame(f, 0);
    check_result("mixed_12288", 17'd12288, 1'b0);
    f = fill(3'd0);
    f[N-1] = 3'b111;
    send_frame(f, 0);
    check_result("minus_one", 17'h1FFFF, 1'b0);
  endtask

  task automatic test_illegal();
    frame_t f;
    f = fill(3'd0);
    f[2] = 3'b100;
    send_frame(f, 0);
    check_result("illegal", 17'h1F000, 1'b1);
    send_frame(fill(3'd1), 0);
    check_result("after_illegal", 17'd21845, 1'b0);
  endtask

  task automatic test_back_to_back();
    bus.dout_ready = 1'b0;
    send_frame(fill(3'd3), 0);
    bus.din       = 3'd1;
    bus.din_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.din_ready !== 1'b0 || bus.dout_valid !== 1'b1 || bus.dout !== 17'h0FFFF) begin
        errors++;
        $display("FAIL hold_cycle%0d: got ready=%b valid=%b dout=%h, required 0/1/0ffff",
                 c, bus.din_ready, bus.dout_valid, bus.dout);
      end
      @(negedge clk);
    end
    bus.dout_ready = 1'b1;
    #1;
    checks++;
    if (bus.din_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got %b, required 1", bus.din_ready);
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_valid_drop: got %b, required 0", bus.dout_valid);
    end
    for (int k = 1; k < int'(N); k++) send_digit(3'd1, 0);
    check_result("after_hold", 17'd21845, 1'b0);
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 4; k++) send_digit(3'd3, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.dout_err !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got dout=%h valid=%b err=%b, required 0/0/0",
               bus.dout, bus.dout_valid, bus.dout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(fill(3'd2), 0);
    check_result("post_reset", 17'd43690, 1'b0);
  endtask

  task automatic test_gaps();
    frame_t f;
    send_frame(fill(3'd2), 3);
    check_result("gapped", 17'd43690, 1'b0);
    f = fill(3'd0);
    f[0] = 3'd1;
    f[1] = 3'b111;
    send_frame(f, 2);
    check_result("gapped_mixed", 17'd12288, 1'b0);
  endtask

  initial begin
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    rst_n          = 1'b0;
    test_reset();
    test_extremes();
    test_mixed();
    test_illegal();
    test_back_to_back();
    test_reset_midframe();
    test_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
